shift_chain_master: RTL and testbench

- Master end of the satellite shift-register chain. It generates the chain's shift clock, load and shift-enable strobes.
- Per transaction it serially writes one WIDTH-bit word into the chain and reads one WIDTH-bit word back from it.
- Sits between the core control logic (parallel side) and the chain of slave shift-register stages (serial side), all clocked on masterClk.
- Provides timing margins so that slaves, which detect edges on masterClk, see every strobe and clock edge cleanly.

---
 rtl/shift_chain_master_pkg.sv | 22 ++
 rtl/shift_phase_timer.sv | 30 +++
 rtl/shift_chain_master.sv | 126 ++++++++++++
 tb/tb_shift_chain_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_chain_master_pkg.sv
// Shared state encoding, parameter limits and counter sizing for the shift-chain master.
package shift_chain_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENABLE,
    LOW,
    HIGH,
    TAIL,
    DISABLE,
    DONE
  } state_t;

  localparam int CLK_DIV_MIN = 2;

  // Bits needed to hold n distinct values (0..n-1), never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_phase_timer.sv
// Loadable down-counter spanning CLK_DIV cycles; lastCycle flags the final cycle of a phase.
// Latency: a load is followed by exactly CLK_DIV cycles, the last one with lastCycle high.
module shift_phase_timer
  import shift_chain_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic masterClk,
  input  logic nReset,
  input  logic load,
  output logic lastCycle
);

  localparam int PW = cnt_width(CLK_DIV);

  logic [PW-1:0] cnt;

  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= PW'(CLK_DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - PW'(1);
    end
  end

  assign lastCycle = (cnt == '0);

endmodule

// File: rtl/shift_chain_master.sv
// Master of the slave shift-register chain: one WIDTH-bit write and read-back per start.
// Latency CLK_DIV*(2*WIDTH+4)+1 cycles from accept to done; start is ignored while busy.
module shift_chain_master
  import shift_chain_master_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             masterClk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic [WIDTH-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             sClk,
  output logic             sLoad,
  output logic             sEnable,
  output logic             sDataOut,
  input  logic             sDataIn
);

  localparam int BW = cnt_width(WIDTH + 1);

  if (WIDTH < 1 || CLK_DIV < CLK_DIV_MIN) begin : g_bad_param
    $error("shift_chain_master: WIDTH must be >= 1 and CLK_DIV >= CLK_DIV_MIN");
  end

  state_t           state;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [BW-1:0]    bit_cnt;
  logic             last_cycle;
  logic             timer_load;

  // Every timed state reloads the timer on its way out; IDLE reloads on accept.
  assign timer_load = (state == IDLE && start) ||
                      (last_cycle && state != IDLE && state != DONE);

  shift_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .masterClk (masterClk),
    .nReset    (nReset),
    .load      (timer_load),
    .lastCycle (last_cycle)
  );

  assign sDataOut = tx_shift[WIDTH-1];

  // Strobes are registered on the transition into the state that owns them.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rxData   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sClk     <= 1'b0;
      sLoad    <= 1'b0;
      sEnable  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= txData;
            rx_shift <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            sLoad    <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (last_cycle) begin
            sEnable <= 1'b1;
            state   <= ENABLE;
          end
        end
        ENABLE: begin
          if (last_cycle) begin
            sLoad <= 1'b0;
            state <= LOW;
          end
        end
        LOW: begin
          if (last_cycle) begin
            rx_shift <= (rx_shift << 1) | WIDTH'(sDataIn);
            sClk     <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (last_cycle) begin
            tx_shift <= tx_shift << 1;
            bit_cnt  <= bit_cnt + BW'(1);
            sClk     <= 1'b0;
            state    <= (bit_cnt == BW'(WIDTH - 1)) ? TAIL : LOW;
          end
        end
        TAIL: begin
          if (last_cycle) begin
            sEnable <= 1'b0;
            state   <= DISABLE;
          end
        end
        DISABLE: begin
          if (last_cycle) begin
            done   <= 1'b1;
            rxData <= rx_shift;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_master.sv
// Bench: two masters (8-bit/div 4 and 1-bit/div 2), each driving a behavioural slave stage.
module tb_shift_chain_master;

  localparam int WA    = 8;
  localparam int CA    = 4;
  localparam int WB    = 1;
  localparam int CB    = 2;
  localparam int LAT_A = CA * (2 * WA + 4) + 1;
  localparam int LAT_B = CB * (2 * WB + 4) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic          start_a;
  logic [WA-1:0] tx_a, rx_a;
  logic          busy_a, done_a, sclk_a, ld_a, en_a, sdo_a, sdi_a;

  shift_chain_master #(.WIDTH(WA), .CLK_DIV(CA)) dut_a (
    .masterClk (clk),    .nReset  (rst_n),  .start    (start_a),
    .txData    (tx_a),   .rxData  (rx_a),   .busy     (busy_a),
    .done      (done_a), .sClk    (sclk_a), .sLoad    (ld_a),
    .sEnable   (en_a),   .sDataOut(sdo_a),  .sDataIn  (sdi_a)
  );

  // Slave stage: loads on sEnable rise with sLoad, shifts on sClk rise, latches on sEnable fall.
  logic [WA-1:0] sl_sh_a = '0, sl_in_a = '0, sl_out_a = '0;
  logic          p_clk_a = 1'b0, p_en_a = 1'b0;
  always @(posedge clk) begin
    if (en_a && !p_en_a && ld_a) sl_sh_a <= sl_in_a;
    else if (sclk_a && !p_clk_a) sl_sh_a <= {sl_sh_a[WA-2:0], sdo_a};
    if (!en_a && p_en_a) sl_out_a <= sl_sh_a;
    p_clk_a <= sclk_a;
    p_en_a  <= en_a;
  end
  assign sdi_a = sl_sh_a[WA-1];

  // ---------------- instance B ----------------
  logic          start_b;
  logic [WB-1:0] tx_b, rx_b;
  logic          busy_b, done_b, sclk_b, ld_b, en_b, sdo_b, sdi_b;

  shift_chain_master #(.WIDTH(WB), .CLK_DIV(CB)) dut_b (
    .masterClk (clk),    .nReset  (rst_n),  .start    (start_b),
    .txData    (tx_b),   .rxData  (rx_b),   .busy     (busy_b),
    .done      (done_b), .sClk    (sclk_b), .sLoad    (ld_b),
    .sEnable   (en_b),   .sDataOut(sdo_b),  .sDataIn  (sdi_b)
  );

  logic sl_sh_b = 1'b0, sl_in_b = 1'b0, sl_out_b = 1'b0;
  logic p_clk_b = 1'b0, p_en_b = 1'b0;
  always @(posedge clk) begin
    if (en_b && !p_en_b && ld_b) sl_sh_b <= sl_in_b;
    else if (sclk_b && !p_clk_b) sl_sh_b <= sdo_b;
    if (!en_b && p_en_b) sl_out_b <= sl_sh_b;
    p_clk_b <= sclk_b;
    p_en_b  <= en_b;
  end
  assign sdi_b = sl_sh_b;

  // One transaction on A, called at a negedge with A idle. noisy: random start/txData while busy.
  // rst_at > 0: pulse reset at that cycle after accept and check the outputs collapse.
  task automatic txn_a(input logic [WA-1:0] tx, input logic [WA-1:0] pin,
                       input bit noisy, input int rst_at);
    int k, done_k, n_done, n_rise, first_ld, last_ld, first_en, last_en, first_clk, last_clk;
    logic prev;
    sl_in_a = pin;
    start_a = 1'b1;
    tx_a    = tx;
    @(negedge clk);
    start_a = 1'b0;
    k = 1; done_k = 0; n_done = 0; n_rise = 0; prev = 1'b0;
    first_ld = 0; last_ld = 0; first_en = 0; last_en = 0; first_clk = 0; last_clk = 0;
    while (k <= LAT_A + 2) begin
      if (rst_at == k) begin
        rst_n = 1'b0;
        #1;
        check("rst_strobes", {sclk_a, ld_a, en_a, sdo_a, done_a}, 5'b0);
        check("rst_busy", busy_a, 0);
        check("rst_rx", rx_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (ld_a && first_ld == 0) first_ld = k;
      if (ld_a) last_ld = k;
      if (en_a && first_en == 0) first_en = k;
      if (en_a) last_en = k;
      if (sclk_a && !prev) begin
        n_rise++;
        if (first_clk == 0) first_clk = k;
      end
      if (sclk_a) last_clk = k;
      prev = sclk_a;
      if (done_a) begin
        n_done++;
        if (done_k == 0) done_k = k;
        check("busy_at_done", busy_a, 1);
      end
      if (noisy) begin
        start_a = (k < LAT_A - 1) ? 1'($urandom % 2) : 1'b0;
        tx_a    = WA'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start_a = 1'b0;
    check("latency", done_k, LAT_A);
    check("done_width", n_done, 1);
    check("sclk_rises", n_rise, WA);
    check("load_lead", first_en - first_ld, CA);
    check("load_low_before_sclk", first_clk > last_ld, 1);
    check("enable_tail", last_en - last_clk, CA);
    check("rx_data", rx_a, pin);
    check("slave_out", sl_out_a, tx);
    check("busy_after", busy_a, 0);
  endtask

  task automatic txn_b(input logic tx, input logic pin);
    int k, done_k, n_rise;
    logic prev;
    sl_in_b = pin;
    start_b = 1'b1;
    tx_b    = tx;
    @(negedge clk);
    start_b = 1'b0;
    k = 1; done_k = 0; n_rise = 0; prev = 1'b0;
    while (k <= LAT_B + 2) begin
      if (sclk_b && !prev) n_rise++;
      prev = sclk_b;
      if (done_b && done_k == 0) done_k = k;
      @(negedge clk);
      k++;
    end
    check("b_latency", done_k, LAT_B);
    check("b_sclk_rises", n_rise, WB);
    check("b_rx_data", rx_b, pin);
    check("b_slave_out", sl_out_b, tx);
  endtask

  // start held high across three transactions; one idle cycle expected between each.
  task automatic held_start();
    logic [WA-1:0] vals [3];
    int idx, idle, n_done;
    bit gap;
    vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF;
    idx = 0; idle = 0; n_done = 0; gap = 1'b0;
    sl_in_a = WA'($urandom);
    start_a = 1'b1;
    tx_a    = vals[0];
    for (int k = 0; k < 3 * (LAT_A + 2) + 6; k++) begin
      @(negedge clk);
      if (gap) begin
        if (busy_a) begin
          check("idle_gap", idle, 1);
          gap = 1'b0;
        end else begin
          idle++;
        end
      end
      if (done_a) begin
        n_done++;
        if (idx < 3) check("held_slave_out", sl_out_a, vals[idx]);
        idx++;
        if (idx < 3) begin
          tx_a = vals[idx];
          gap  = 1'b1;
          idle = 0;
        end else begin
          start_a = 1'b0;
        end
      end
    end
    start_a = 1'b0;
    check("held_done_count", n_done, 3);
    check("held_busy_after", busy_a, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tx_a    = '0;
    tx_b    = '0;
    repeat (3) @(negedge clk);
    check("reset_a_outputs", {busy_a, done_a, sclk_a, ld_a, en_a, sdo_a}, 6'b0);
    check("reset_a_rx", rx_a, 0);
    check("reset_b_outputs", {busy_b, done_b, sclk_b, ld_b, en_b, sdo_b, rx_b}, 7'b0);
    rst_n = 1'b1;
    @(negedge clk);

    txn_a(8'hC3, 8'h3C, 1'b0, 0);
    for (int i = 0; i < 6; i++) txn_a(WA'($urandom), WA'($urandom), 1'b1, 0);
    held_start();
    @(negedge clk);
    // 4th HIGH phase spans cycles 9*CA+1 .. 10*CA after accept.
    txn_a(8'hE7, WA'($urandom), 1'b0, 9 * CA + 2);
    @(negedge clk);
    txn_a(8'h5A, WA'($urandom), 1'b0, 0);

    txn_b(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) txn_b(1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
